// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared types and constants for the D-PHY lane sequencer
package dphy_pkg;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_LPX,
    ST_PREP,
    ST_HS_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_TRAIL,
    ST_EXIT
  } dphy_state_e;

  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

  // LP pair encodings as {lp_p, lp_n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  function automatic logic [1:0] dphy_lp_levels(input dphy_state_e st);
    case (st)
      ST_STOP, ST_EXIT: dphy_lp_levels = LP11;
      ST_LPX:           dphy_lp_levels = LP01;
      default:          dphy_lp_levels = LP00;
    endcase
  endfunction

  function automatic int dphy_max(input int a, input int b);
    dphy_max = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dphy_hs_serializer.sv
// rtl/dphy_hs_serializer.sv - 8-bit LSB-first load/shift register with bit counter and trail bit
module dphy_hs_serializer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       capture_i,
  input  logic [7:0] din_i,
  output logic [2:0] bit_cnt_o,
  output logic       next_bit_o,
  output logic       trail_bit_o
);

  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic       last_bit_q;

  // sr_q[0] is the bit on the line this cycle; next_bit_o is what follows it
  assign next_bit_o  = load_i ? din_i[0] : sr_q[1];
  assign trail_bit_o = ~(capture_i ? sr_q[0] : last_bit_q);
  assign bit_cnt_o   = bit_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      last_bit_q <= 1'b0;
    end else begin
      if (load_i) begin
        sr_q      <= din_i;
        bit_cnt_q <= '0;
      end else if (shift_i) begin
        sr_q      <= {1'b0, sr_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (capture_i) last_bit_q <= sr_q[0];
    end
  end

endmodule

// File: rtl/dphy_lane_sequencer.sv
// rtl/dphy_lane_sequencer.sv - D-PHY data lane transmit sequencer (LP/SoT/HS payload/trail/exit)
module dphy_lane_sequencer
  import dphy_pkg::*;
#(
  parameter int T_LPX   = 4,
  parameter int T_PREP  = 3,
  parameter int T_ZERO  = 6,
  parameter int T_TRAIL = 5,
  parameter int T_EXIT  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic       lp_p_o,
  output logic       lp_n_o,
  output logic       hs_en_o,
  output logic       hs_d_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int T_MAX = dphy_max(dphy_max(dphy_max(T_LPX, T_PREP), dphy_max(T_ZERO, T_TRAIL)), T_EXIT);
  localparam int TW    = $clog2(T_MAX) + 1;

  dphy_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          last_q, last_d;
  logic          underrun_d;
  logic          ser_load, ser_shift, ser_capture;
  logic [7:0]    ser_din;
  logic [2:0]    bit_cnt;
  logic          ser_next_bit, ser_trail_bit;

  dphy_hs_serializer u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ser_load),
    .shift_i    (ser_shift),
    .capture_i  (ser_capture),
    .din_i      (ser_din),
    .bit_cnt_o  (bit_cnt),
    .next_bit_o (ser_next_bit),
    .trail_bit_o(ser_trail_bit)
  );

  assign s_ready_o   = (bit_cnt == 3'd7) &&
                       ((state_q == ST_SYNC) || (state_q == ST_DATA && !last_q));
  assign ser_capture = (state_q == ST_SYNC) || (state_q == ST_DATA);

  always_comb begin
    state_d    = state_q;
    tmr_d      = (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_din    = DPHY_SYNC_BYTE;
    case (state_q)
      ST_STOP: if (s_valid_i) begin
        state_d = ST_LPX;
        tmr_d   = TW'(T_LPX - 1);
      end
      ST_LPX: if (tmr_q == '0) begin
        state_d = ST_PREP;
        tmr_d   = TW'(T_PREP - 1);
      end
      ST_PREP: if (tmr_q == '0) begin
        state_d = ST_HS_ZERO;
        tmr_d   = TW'(T_ZERO - 1);
      end
      ST_HS_ZERO: if (tmr_q == '0) begin
        state_d  = ST_SYNC;
        ser_load = 1'b1;
      end
      ST_SYNC, ST_DATA: begin
        if (bit_cnt != 3'd7) begin
          ser_shift = 1'b1;
        end else if (s_ready_o && s_valid_i) begin
          state_d  = ST_DATA;
          ser_load = 1'b1;
          ser_din  = s_data_i;
          last_d   = s_last_i;
        end else begin
          // either the packet ended or the source starved us; both close with a trail
          underrun_d = s_ready_o;
          state_d    = ST_TRAIL;
          tmr_d      = TW'(T_TRAIL - 1);
        end
      end
      ST_TRAIL: if (tmr_q == '0) begin
        state_d = ST_EXIT;
        tmr_d   = TW'(T_EXIT - 1);
      end
      ST_EXIT: if (tmr_q == '0) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_STOP;
      tmr_q      <= '0;
      last_q     <= 1'b0;
      lp_p_o     <= 1'b1;
      lp_n_o     <= 1'b1;
      hs_en_o    <= 1'b0;
      hs_d_o     <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state_q            <= state_d;
      tmr_q              <= tmr_d;
      last_q             <= last_d;
      {lp_p_o, lp_n_o}   <= dphy_lp_levels(state_d);
      hs_en_o            <= state_d inside {ST_HS_ZERO, ST_SYNC, ST_DATA, ST_TRAIL};
      busy_o             <= (state_d != ST_STOP);
      underrun_o         <= underrun_d;
      case (state_d)
        ST_SYNC, ST_DATA: hs_d_o <= ser_next_bit;
        ST_TRAIL:         hs_d_o <= ser_trail_bit;
        default:          hs_d_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dphy_lane_sequencer.sv
// tb/tb_dphy_lane_sequencer.sv - scoreboard bench for the D-PHY lane sequencer
module tb_dphy_lane_sequencer;

  typedef struct packed {
    logic lp_p;
    logic lp_n;
    logic hs_en;
    logic hs_d;
    logic busy;
    logic underrun;
    logic ready;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_last;
  logic       valid_a, valid_b;
  logic       ready_a, lpp_a, lpn_a, en_a, d_a, busy_a, ur_a;
  logic       ready_b, lpp_b, lpn_b, en_b, d_b, busy_b, ur_b;

  always #5 clk = ~clk;

  dphy_lane_sequencer dut_a (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(valid_a), .s_last_i(s_last),
    .s_ready_o(ready_a), .lp_p_o(lpp_a), .lp_n_o(lpn_a), .hs_en_o(en_a), .hs_d_o(d_a),
    .busy_o(busy_a), .underrun_o(ur_a)
  );

  dphy_lane_sequencer #(.T_LPX(1), .T_PREP(1), .T_ZERO(1), .T_TRAIL(1), .T_EXIT(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(valid_b), .s_last_i(s_last),
    .s_ready_o(ready_b), .lp_p_o(lpp_b), .lp_n_o(lpn_b), .hs_en_o(en_b), .hs_d_o(d_b),
    .busy_o(busy_b), .underrun_o(ur_b)
  );

  obs_t       exp_q[$];
  logic [7:0] st_data[$];
  logic       st_last[$];
  logic [7:0] tmp1[$];
  logic [7:0] tmp2[$];
  int         st_avail;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_ready;
  int         p_lpx, p_prep, p_zero, p_trail, p_exit;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [1:0] lp, input logic en, input logic d,
                              input logic busy, input logic ur, input logic rdy);
    obs_t o;
    o.lp_p = lp[1]; o.lp_n = lp[0]; o.hs_en = en; o.hs_d = d;
    o.busy = busy; o.underrun = ur; o.ready = rdy;
    return o;
  endfunction

  task automatic push_n(input obs_t o, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  // expected line state per cycle, starting with the STOP cycle that sees s_valid
  task automatic model_packet(input logic [7:0] bytes[$], input int n_sent, input bit starve);
    logic [7:0] sb;
    logic       lastbit;
    logic       rdy;
    sb = 8'hB8;
    lastbit = 1'b0;
    exp_q.push_back(mk(2'b11, 0, 0, 0, 0, 0));
    push_n(mk(2'b01, 0, 0, 1, 0, 0), p_lpx);
    push_n(mk(2'b00, 0, 0, 1, 0, 0), p_prep);
    push_n(mk(2'b00, 1, 0, 1, 0, 0), p_zero);
    for (int i = 0; i < 8; i++) begin
      rdy = (i == 7);
      if (rdy) exp_ready++;
      exp_q.push_back(mk(2'b00, 1, sb[i], 1, 0, rdy));
      lastbit = sb[i];
    end
    for (int b = 0; b < n_sent; b++) begin
      for (int i = 0; i < 8; i++) begin
        rdy = (i == 7) && ((b < n_sent - 1) || starve);
        if (rdy) exp_ready++;
        exp_q.push_back(mk(2'b00, 1, bytes[b][i], 1, 0, rdy));
        lastbit = bytes[b][i];
      end
    end
    exp_q.push_back(mk(2'b00, 1, ~lastbit, 1, starve, 0));
    push_n(mk(2'b00, 1, ~lastbit, 1, 0, 0), p_trail - 1);
    push_n(mk(2'b11, 0, 0, 1, 0, 0), p_exit);
  endtask

  task automatic run(input string name, input bit use_b, input int max_cycles);
    int   idx = 0;
    int   cyc = 0;
    int   rdy_cnt = 0;
    int   run11 = 0;
    bit   seen_trail = 0;
    bit   fire;
    logic v;
    obs_t e, got;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      e = exp_q.pop_front();
      got = use_b ? mk({lpp_b, lpn_b}, en_b, d_b, busy_b, ur_b, ready_b)
                  : mk({lpp_a, lpn_a}, en_a, d_a, busy_a, ur_a, ready_a);
      check_eq($sformatf("%s cyc%0d", name, cyc), got, e);
      if (got.ready) rdy_cnt++;
      if (got.hs_en) begin
        seen_trail = 1;
        run11 = 0;
      end else if (got.lp_p && got.lp_n) begin
        run11++;
      end else if (!got.lp_p && got.lp_n && seen_trail) begin
        check_eq({name, " lp11_gap"}, run11, p_exit + 1);
        seen_trail = 0;
      end
      v = (idx < st_avail);
      s_data = v ? st_data[idx] : 8'h00;
      s_last = v ? st_last[idx] : 1'b0;
      if (use_b) valid_b = v; else valid_a = v;
      @(negedge clk);
      fire = v && (use_b ? ready_b : ready_a);
      @(posedge clk);
      #1;
      if (fire) idx++;
      cyc++;
    end
    valid_a = 0;
    valid_b = 0;
    if (exp_q.size() == 0) begin
      check_eq({name, " ready_cnt"}, rdy_cnt, exp_ready);
      check_eq({name, " consumed"}, idx, st_avail);
    end
  endtask

  task automatic set_params(input int a, input int b, input int c, input int d, input int e);
    p_lpx = a; p_prep = b; p_zero = c; p_trail = d; p_exit = e;
  endtask

  initial begin
    rst = 1; valid_a = 0; valid_b = 0; s_data = 0; s_last = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_a", mk({lpp_a, lpn_a}, en_a, d_a, busy_a, ur_a, ready_a), mk(2'b11, 0, 0, 0, 0, 0));
    check_eq("reset_b", mk({lpp_b, lpn_b}, en_b, d_b, busy_b, ur_b, ready_b), mk(2'b11, 0, 0, 0, 0, 0));
    rst = 0;
    @(posedge clk);
    #1;
    set_params(4, 3, 6, 5, 8);

    st_data = '{8'h5A}; st_last = '{1'b1}; st_avail = 1; exp_ready = 0;
    model_packet(st_data, 1, 0);
    push_n(mk(2'b11, 0, 0, 0, 0, 0), 2);
    run("single", 0, 2000);

    st_data = '{8'h01, 8'h02, 8'h03}; st_last = '{1'b0, 1'b0, 1'b1}; st_avail = 3; exp_ready = 0;
    model_packet(st_data, 3, 0);
    push_n(mk(2'b11, 0, 0, 0, 0, 0), 2);
    run("three", 0, 2000);

    st_data = '{8'h11, 8'h22}; st_last = '{1'b0, 1'b1}; st_avail = 1; exp_ready = 0;
    model_packet(st_data, 1, 1);
    push_n(mk(2'b11, 0, 0, 0, 0, 0), 2);
    run("underrun", 0, 2000);

    st_data = '{8'hC3, 8'h3C, 8'h81}; st_last = '{1'b0, 1'b0, 1'b1}; st_avail = 3; exp_ready = 0;
    model_packet(st_data, 3, 0);
    run("pre_reset", 0, 25);
    exp_q.delete();
    rst = 1;
    @(posedge clk);
    #1;
    check_eq("mid_reset", mk({lpp_a, lpn_a}, en_a, d_a, busy_a, ur_a, ready_a), mk(2'b11, 0, 0, 0, 0, 0));
    rst = 0;
    st_data = '{8'hA5}; st_last = '{1'b1}; st_avail = 1; exp_ready = 0;
    model_packet(st_data, 1, 0);
    push_n(mk(2'b11, 0, 0, 0, 0, 0), 2);
    run("post_reset", 0, 2000);

    tmp1 = '{8'h96}; tmp2 = '{8'h6B};
    st_data = '{8'h96, 8'h6B}; st_last = '{1'b1, 1'b1}; st_avail = 2; exp_ready = 0;
    model_packet(tmp1, 1, 0);
    model_packet(tmp2, 1, 0);
    push_n(mk(2'b11, 0, 0, 0, 0, 0), 2);
    run("b2b", 0, 2000);

    set_params(1, 1, 1, 1, 1);
    st_data = '{8'hE7, 8'h18}; st_last = '{1'b0, 1'b1}; st_avail = 2; exp_ready = 0;
    model_packet(st_data, 2, 0);
    push_n(mk(2'b11, 0, 0, 0, 0, 0), 2);
    run("sweep", 1, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dphy_lane_sequencer.md
# dphy_lane_sequencer

Synthesizable transmit sequencer for one MIPI D-PHY data lane. It accepts a packet as a byte stream over a valid/ready handshake and drives the low-power (LP) line pair and the high-speed (HS) enable and serial data. For each packet it sequences LP-11 stop, SoT (LP-01, LP-00, HS-zero, sync byte), LSB-first payload, HS trail and LP-11 exit. It sits between the packet builder and the lane PHY primitive/IO and replaces hand-driven lane stimulus in the CSI-2 transmit path.

## Interface
- T_LPX, 4: cycles of LP-01 (request); must be ≥1.
- T_PREP, 3: cycles of LP-00 (HS-prepare); must be ≥1.
- T_ZERO, 6: cycles of HS-zero (hs_en=1, data 0); must be ≥1.
- T_TRAIL, 5: cycles of trail (inverted last bit); must be ≥1.
- T_EXIT, 8: cycles of LP-11 after trail before a new SoT; must be ≥1.
- clk_i  in  1  bit clock; one HS bit per cycle; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- s_data_i  in  8  payload byte.
- s_valid_i  in  1  byte valid.
- s_last_i  in  1  byte is the last of the packet; qualified with s_valid_i.
- s_ready_o  out  1  byte accepted when s_valid_i & s_ready_o.
- lp_p_o / lp_n_o  out  1 each  LP line levels.
- hs_en_o  out  1  HS driver enable.
- hs_d_o  out  1  HS serial data.
- busy_o  out  1  high in every state except STOP.
- underrun_o  out  1  one-cycle pulse when a byte was required and s_valid_i was low.

## Operation
- States: STOP, LPX, PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT.
- STOP: lp=11, hs_en=0, hs_d=0. If s_valid_i=1, go to LPX next cycle. The byte is not consumed.
- LPX: lp=01 for T_LPX cycles, then PREP.
- PREP: lp=00 for T_PREP cycles, then HS_ZERO.
- HS_ZERO: lp=00, hs_en=1, hs_d=0 for T_ZERO cycles, then SYNC.
- SYNC: shifts 8'hB8 LSB-first, one bit per cycle (0,0,0,1,1,1,0,1).
- Byte load:
  - s_ready_o is combinational: 1 in SYNC bit 7, and in DATA bit 7 when the current byte is not last. 0 everywhere else.
  - On transfer, the byte loads into the shift register and last_q ← s_last_i. Next state is DATA, bit 0.
  - If s_ready_o=1 and s_valid_i=0: underrun_o pulses and the next state is TRAIL.
- DATA: hs_d = shift[0], shifting right every cycle; 3-bit bit counter. At bit 7 with last_q=1, go to TRAIL.
- TRAIL: hs_en=1, hs_d = ~(last driven HS bit), held for T_TRAIL cycles. Underrun trail inverts the last driven bit (sync bit 7 = 1 if no payload was sent). Then EXIT.
- EXIT: lp=11, hs_en=0 for T_EXIT cycles, then STOP. s_valid_i is ignored in EXIT.
- Packets have no length limit.
- Timing counter:
  - One shared down-counter, width $clog2(max parameter)+1.
  - Loads param−1 on state entry; the state exits when the counter is 0.
  - SYNC/DATA use the bit counter instead.
- Reset:
  - Forces STOP from any state, including mid-packet, with no trail. Shift register and counters clear.
  - Reset values: lp_p_o=1, lp_n_o=1, hs_en_o=0, hs_d_o=0, s_ready_o=0, busy_o=0, underrun_o=0.

## Timing
- All outputs are registered except s_ready_o (combinational from state and bit counter).
- Let cycle 0 be the cycle s_valid_i is seen high in STOP:
  - LPX occupies cycles 1..T_LPX.
  - The first sync bit is at cycle 1+T_LPX+T_PREP+T_ZERO.
  - The first payload bit follows 8 cycles later (default: cycle 22).
- A packet of N bytes holds hs_en=1 for T_ZERO+8+8N+T_TRAIL cycles.
- Back-to-back packets: minimum gap of T_EXIT+1 cycles at LP-11 between trail end and the next LP-01.
- s_last_i on the first byte is legal: 1-byte packet, then TRAIL.

## Structure
- Shared package dphy_pkg:
  - state enum.
  - DPHY_SYNC_BYTE = 8'hB8.
  - LP encodings LP11/LP01/LP00.
- One natural sub-module: dphy_hs_serializer, an 8-bit load/shift register with bit counter and last-bit capture for trail.
- The FSM and timer stay in the top level.

## Test plan
- Single byte 8'h5A, last=1, default params:
  - LP 11→01 (4 cycles)→00 (3)→HS zero (6).
  - Bits 0,0,0,1,1,1,0,1 then 0,1,0,1,1,0,1,0.
  - Trail = 1 for 5 cycles, LP-11 for 8 cycles, busy_o falls.
- 3-byte packet 01,02,03, valid held high:
  - s_ready_o high exactly 3 cycles, 8 cycles apart.
  - 24 contiguous payload bits; trail = 1 (inverse of bit 7 of 03).
- Underrun: 2-byte packet, valid dropped before byte 2 → underrun_o single pulse at DATA bit 7 of byte 1, trail then exit, no second byte consumed.
- Reset asserted mid-DATA → next cycle lp=11, hs_en=0, busy=0, s_ready=0; a fresh packet then starts a clean SoT.
- Back-to-back packets with valid held through EXIT → second LP-01 begins exactly T_EXIT+1 cycles after trail ends.
- Parameter sweep (T_LPX=1, T_ZERO=1, T_TRAIL=1) → each phase lasts exactly one cycle; a scoreboard checks every phase duration.
